mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port program/data memory of the Sextium III core between the CPU controller (fetch, LOAD, STORE, CONST) and the IO/DMA engine that services SYSCALL transfers. Each requester issues one access at a time through a req/ack handshake. The arbiter grants one requester, drives the memory for exactly one access, waits the memory's fixed read latency, returns read data and acknowledges. It sits between the controller/datapath address mux and the memory macro.

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter sharing one single-port memory between CPU and IO.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: CPU priority).
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic [DW-1:0] io_rdata,
    output logic          io_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] io_rdata_q, io_rdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          io_ack_q, io_ack_d;
    logic          busy_q, busy_d;
    logic          grant_io;
    logic          done_now;

    assign done_now = (state_q == ACCESS) && (cnt_q == 3'd0);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;

    // On a tie the requester that did not own the last grant wins.
    assign grant_io = io_req & (~cpu_req | ~last_owner_q);

    always_comb begin
        last_owner_d = last_owner_q;
        if (done_now)
            last_owner_d = owner_q;
    end

    always_ff @(posedge clock) begin
        if (!reset)
            last_owner_q <= 1'b1;
        else
            last_owner_q <= last_owner_d;
    end
`else
    assign grant_io = ~cpu_req;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        io_rdata_d  = io_rdata_q;
        cpu_ack_d   = 1'b0;
        io_ack_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req || io_req) begin
                    owner_d     = grant_io;
                    we_d        = grant_io ? io_we : cpu_we;
                    mem_addr_d  = grant_io ? io_addr : cpu_addr;
                    mem_wdata_d = grant_io ? io_wdata : cpu_wdata;
                    cnt_d       = LAT_M1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_d;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 3'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q)
                            io_rdata_d = mem_rdata;
                        else
                            cpu_rdata_d = mem_rdata;
                    end
                    if (owner_q)
                        io_ack_d = 1'b1;
                    else
                        cpu_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= 3'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
            cpu_ack_q   <= 1'b0;
            io_ack_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            io_rdata_q  <= io_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            io_ack_q    <= io_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign io_rdata  = io_rdata_q;
    assign io_ack    = io_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: L=1 instance for protocol/arbitration,
// L=3 instance for the longer read latency.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;

    logic        c_req, c_we, i_req, i_we;
    logic [15:0] c_addr, c_wdata, i_addr, i_wdata;
    logic [15:0] c_rdata, i_rdata;
    logic        c_ack, i_ack;
    logic        m_en, m_we, busy;
    logic [15:0] m_addr, m_wdata, m_rdata;

    logic        z_bit;
    logic [15:0] z_word;
    logic        i3_req;
    logic [15:0] i3_addr;
    logic [15:0] c3_rdata, i3_rdata;
    logic        c3_ack, i3_ack;
    logic        m3_en, m3_we, busy3;
    logic [15:0] m3_addr, m3_wdata, m3_rdata;

    logic [15:0] mem1 [256];
    logic [15:0] mem3 [256];
    int          age3;

    int          nchk;
    int          nerr;
    bit          last_io;
    logic [15:0] exp_crd, exp_ird;

    mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) dut1 (
        .clock(clock), .reset(reset),
        .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr),
        .cpu_wdata(c_wdata), .cpu_rdata(c_rdata), .cpu_ack(c_ack),
        .io_req(i_req), .io_we(i_we), .io_addr(i_addr),
        .io_wdata(i_wdata), .io_rdata(i_rdata), .io_ack(i_ack),
        .mem_en(m_en), .mem_we(m_we), .mem_addr(m_addr),
        .mem_wdata(m_wdata), .mem_rdata(m_rdata), .busy(busy)
    );

    mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) dut3 (
        .clock(clock), .reset(reset),
        .cpu_req(z_bit), .cpu_we(z_bit), .cpu_addr(z_word),
        .cpu_wdata(z_word), .cpu_rdata(c3_rdata), .cpu_ack(c3_ack),
        .io_req(i3_req), .io_we(z_bit), .io_addr(i3_addr),
        .io_wdata(z_word), .io_rdata(i3_rdata), .io_ack(i3_ack),
        .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr),
        .mem_wdata(m3_wdata), .mem_rdata(m3_rdata), .busy(busy3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // L=1 memory: data valid only in the mem_en cycle.
    assign m_rdata = m_en ? mem1[m_addr[7:0]] : 16'hDEAD;

    always @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < 256; k++)
                mem1[k] <= 16'hA000 + 16'(k);
        end else if (m_en && m_we) begin
            mem1[m_addr[7:0]] <= m_wdata;
        end
    end

    // L=3 memory: data valid only two cycles after the mem_en cycle.
    assign m3_rdata = (!m3_en && age3 == 2) ? mem3[m3_addr[7:0]] : 16'hDEAD;

    always @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < 256; k++)
                mem3[k] <= (k == 8'h40) ? 16'hBEEF : 16'h0000;
            age3 <= 99;
        end else begin
            if (m3_en && m3_we)
                mem3[m3_addr[7:0]] <= m3_wdata;
            age3 <= m3_en ? 1 : ((age3 < 99) ? age3 + 1 : age3);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit pick_io(input bit c, input bit i);
`ifdef ARB_ROUND_ROBIN_EN
        return i && (!c || !last_io);
`else
        return i && !c;
`endif
    endfunction

    // One uncontended access on the L=1 instance, checked cycle by cycle.
    task automatic acc1(input bit io, input bit we, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] rd);
        if (io) begin
            i_req = 1'b1; i_we = we; i_addr = a; i_wdata = wd;
        end else begin
            c_req = 1'b1; c_we = we; c_addr = a; c_wdata = wd;
        end
        tick();
        check("acc_en", 32'(m_en), 32'(1));
        check("acc_we", 32'(m_we), 32'(we));
        check("acc_addr", 32'(m_addr), 32'(a));
        if (we)
            check("acc_wdata", 32'(m_wdata), 32'(wd));
        check("acc_busy", 32'(busy), 32'(1));
        check("acc_early_ack", 32'(c_ack | i_ack), 32'(0));
        tick();
        if (!we) begin
            if (io) exp_ird = rd;
            else exp_crd = rd;
        end
        check("acc_cack", 32'(c_ack), 32'(!io));
        check("acc_iack", 32'(i_ack), 32'(io));
        check("acc_en_off", 32'(m_en), 32'(0));
        check("acc_we_off", 32'(m_we), 32'(0));
        check("acc_crd", 32'(c_rdata), 32'(exp_crd));
        check("acc_ird", 32'(i_rdata), 32'(exp_ird));
        if (io) i_req = 1'b0;
        else c_req = 1'b0;
        last_io = io;
        tick();
        check("acc_idle", 32'(busy), 32'(0));
        check("acc_ack_off", 32'(c_ack | i_ack), 32'(0));
        check("acc_crd_hold", 32'(c_rdata), 32'(exp_crd));
    endtask

    initial begin
        bit io;
        nchk = 0; nerr = 0;
        last_io = 1'b1;
        exp_crd = '0; exp_ird = '0;
        reset = 1'b0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
        z_bit = 0; z_word = '0; i3_req = 0; i3_addr = '0;

        repeat (3) tick();
        check("rst_en", 32'(m_en), 32'(0));
        check("rst_we", 32'(m_we), 32'(0));
        check("rst_addr", 32'(m_addr), 32'(0));
        check("rst_wdata", 32'(m_wdata), 32'(0));
        check("rst_acks", 32'({c_ack, i_ack}), 32'(0));
        check("rst_crd", 32'(c_rdata), 32'(0));
        check("rst_ird", 32'(i_rdata), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        reset = 1'b1;
        tick();

        // CPU write then read back
        acc1(1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0000);
        acc1(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234);

        // Simultaneous reads: grants at cycles 1 and 4, acks at 2 and 5
        c_req = 1; c_we = 0; c_addr = 16'h0005;
        i_req = 1; i_we = 0; i_addr = 16'h0006;
        for (int k = 0; k < 2; k++) begin
            io = pick_io(c_req, i_req);
            tick();
            check("tie_en", 32'(m_en), 32'(1));
            check("tie_addr", 32'(m_addr), io ? 32'h6 : 32'h5);
            tick();
            if (io) exp_ird = 16'hA006;
            else exp_crd = 16'hA005;
            check("tie_cack", 32'(c_ack), 32'(!io));
            check("tie_iack", 32'(i_ack), 32'(io));
            check("tie_crd", 32'(c_rdata), 32'(exp_crd));
            check("tie_ird", 32'(i_rdata), 32'(exp_ird));
            if (io) i_req = 0;
            else c_req = 0;
            last_io = io;
            tick();
            check("tie_gap", 32'(m_en), 32'(0));
        end
        check("tie_done", 32'(busy), 32'(0));

        // Reset during the ACCESS cycle of a CPU read
        c_req = 1; c_we = 0; c_addr = 16'h0007;
        tick();
        check("ra_en", 32'(m_en), 32'(1));
        reset = 1'b0;
        tick();
        check("ra_cack", 32'(c_ack), 32'(0));
        check("ra_crd", 32'(c_rdata), 32'(0));
        check("ra_busy", 32'(busy), 32'(0));
        check("ra_en_off", 32'(m_en), 32'(0));
        reset = 1'b1;
        c_req = 0;
        exp_crd = '0; exp_ird = '0;
        last_io = 1'b1;
        tick();

        // Both requesters hold req for 4 grants
        c_req = 1; c_we = 0; c_addr = 16'h0001;
        i_req = 1; i_we = 0; i_addr = 16'h0002;
        for (int k = 0; k < 4; k++) begin
            io = pick_io(c_req, i_req);
            tick();
            check("hold_en", 32'(m_en), 32'(1));
            check("hold_addr", 32'(m_addr), io ? 32'h2 : 32'h1);
            tick();
            if (io) exp_ird = 16'hA002;
            else exp_crd = 16'hA001;
            check("hold_cack", 32'(c_ack), 32'(!io));
            check("hold_iack", 32'(i_ack), 32'(io));
            check("hold_crd", 32'(c_rdata), 32'(exp_crd));
            check("hold_ird", 32'(i_rdata), 32'(exp_ird));
            last_io = io;
            tick();
        end
        c_req = 0; i_req = 0;
        tick();
        check("hold_idle", 32'(busy), 32'(0));

        // IO write to 0x0020 while a CPU read of it is pending
        i_req = 1; i_we = 1; i_addr = 16'h0020; i_wdata = 16'h5A5A;
        tick();
        check("iow_en", 32'(m_en), 32'(1));
        check("iow_we", 32'(m_we), 32'(1));
        check("iow_addr", 32'(m_addr), 32'h20);
        check("iow_wdata", 32'(m_wdata), 32'h5A5A);
        c_req = 1; c_we = 0; c_addr = 16'h0020;
        tick();
        check("iow_iack", 32'(i_ack), 32'(1));
        check("iow_cack", 32'(c_ack), 32'(0));
        check("iow_crd", 32'(c_rdata), 32'(exp_crd));
        check("iow_ird", 32'(i_rdata), 32'(exp_ird));
        i_req = 0;
        last_io = 1'b1;
        tick();
        check("iow_idle", 32'(busy), 32'(0));
        acc1(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h5A5A);

        // L=3 IO read of 0xBEEF
        i3_req = 1; i3_addr = 16'h0040;
        tick();
        check("l3_en", 32'(m3_en), 32'(1));
        check("l3_addr", 32'(m3_addr), 32'h40);
        check("l3_we", 32'(m3_we), 32'(0));
        check("l3_busy1", 32'(busy3), 32'(1));
        tick();
        check("l3_en_off", 32'(m3_en), 32'(0));
        check("l3_busy2", 32'(busy3), 32'(1));
        check("l3_ack2", 32'(i3_ack), 32'(0));
        tick();
        check("l3_busy3", 32'(busy3), 32'(1));
        check("l3_ack3", 32'(i3_ack), 32'(0));
        tick();
        check("l3_ack4", 32'(i3_ack), 32'(1));
        check("l3_rdata", 32'(i3_rdata), 32'hBEEF);
        check("l3_busy4", 32'(busy3), 32'(1));
        check("l3_cpu", 32'({c3_ack, c3_rdata}), 32'(0));
        i3_req = 0;
        tick();
        check("l3_idle", 32'(busy3), 32'(0));
        check("l3_ack_off", 32'(i3_ack), 32'(0));
        check("l3_wdata", 32'(m3_wdata), 32'(0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
